// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the instruction-fetch stage: NOP encoding, reset PC and FSM states.
package fetch_unit_pkg;

    localparam logic [31:0] NOP_INST         = 32'h0000_0000;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    typedef enum logic [1:0] {
        StRun,
        StHold,
        StDrop
    } fetch_state_e;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return addr & ~32'd3;
    endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction-memory request/acknowledge bus between the fetch stage and instruction memory.
interface fetch_unit_if;

    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ack,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ack,
        output imem_rdata
    );

endinterface

// File: rtl/fetch_unit_pc_reg.sv
// Program counter with synchronous reset; a target load takes priority over the +4 advance.
module fetch_unit_pc_reg #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic [31:0] target,
    input  logic        advance,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4
);

    logic [31:0] pc_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q <= RESET_PC;
        end else if (load) begin
            pc_q <= target;
        end else if (advance) begin
            pc_q <= pc_plus4;
        end
    end

    assign pc       = pc_q;
    assign pc_plus4 = pc_q + 32'd4;

endmodule

// File: rtl/fetch_unit.sv
// MIPS instruction-fetch stage: PC sequencing, imem req/ack handshake, stall hold buffer and
// branch/jump redirect with discard of any wrong-path fetch still in flight.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                stall,
    input  logic                branch_taken,
    input  logic [31:0]         branch_target,
    input  logic                jump,
    input  logic [31:0]         jump_target,
    fetch_unit_if.master        imem,
    output logic [31:0]         inst,
    output logic [31:0]         adder1,
    output logic                flush
);

    fetch_state_e state_q, state_d;

    logic [31:0] hold_inst_q, hold_inst_d;
    logic [31:0] hold_adder1_q, hold_adder1_d;
    logic        hold_valid_q, hold_valid_d;
    logic [31:0] drop_addr_q, drop_addr_d;

    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        pc_load;
    logic        pc_advance;
    logic        redirect;
    logic [31:0] redirect_target;

    assign redirect        = branch_taken | jump;
    assign redirect_target = word_align(branch_taken ? branch_target : jump_target);

    fetch_unit_pc_reg #(
        .RESET_PC (RESET_PC)
    ) u_pc_reg (
        .clk      (clk),
        .rst      (rst),
        .load     (pc_load),
        .target   (redirect_target),
        .advance  (pc_advance),
        .pc       (pc),
        .pc_plus4 (pc_plus4)
    );

    always_comb begin
        state_d        = state_q;
        hold_inst_d    = hold_inst_q;
        hold_adder1_d  = hold_adder1_q;
        hold_valid_d   = hold_valid_q;
        drop_addr_d    = drop_addr_q;
        imem.imem_req  = 1'b0;
        imem.imem_addr = pc;
        inst           = NOP_INST;
        adder1         = 32'd0;
        flush          = 1'b0;
        pc_load        = 1'b0;
        pc_advance     = 1'b0;

        if (!rst) begin
            unique case (state_q)
                StRun: begin
                    imem.imem_req = 1'b1;
                    if (redirect) begin
                        flush        = 1'b1;
                        pc_load      = 1'b1;
                        hold_valid_d = 1'b0;
                        // Request cannot be withdrawn; remember where it went so it can be drained.
                        if (!imem.imem_ack) begin
                            state_d     = StDrop;
                            drop_addr_d = pc;
                        end
                    end else if (imem.imem_ack) begin
                        inst   = imem.imem_rdata;
                        adder1 = pc_plus4;
                        if (stall) begin
                            hold_inst_d   = imem.imem_rdata;
                            hold_adder1_d = pc_plus4;
                            hold_valid_d  = 1'b1;
                            state_d       = StHold;
                        end else begin
                            pc_advance = 1'b1;
                        end
                    end
                end
                StHold: begin
                    if (redirect) begin
                        flush        = 1'b1;
                        pc_load      = 1'b1;
                        hold_valid_d = 1'b0;
                        state_d      = StRun;
                    end else begin
                        if (hold_valid_q) begin
                            inst   = hold_inst_q;
                            adder1 = hold_adder1_q;
                        end
                        if (!stall) begin
                            pc_advance   = 1'b1;
                            hold_valid_d = 1'b0;
                            state_d      = StRun;
                        end
                    end
                end
                StDrop: begin
                    imem.imem_req  = 1'b1;
                    imem.imem_addr = drop_addr_q;
                    if (redirect) begin
                        flush        = 1'b1;
                        pc_load      = 1'b1;
                        hold_valid_d = 1'b0;
                    end
                    if (imem.imem_ack) begin
                        state_d = StRun;
                    end
                end
                default: state_d = StRun;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= StRun;
            hold_inst_q   <= NOP_INST;
            hold_adder1_q <= 32'd0;
            hold_valid_q  <= 1'b0;
            drop_addr_q   <= 32'd0;
        end else begin
            state_q       <= state_d;
            hold_inst_q   <= hold_inst_d;
            hold_adder1_q <= hold_adder1_d;
            hold_valid_q  <= hold_valid_d;
            drop_addr_q   <= drop_addr_d;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: latency-programmable imem model plus a per-cycle expectation queue.
module tb_fetch_unit;

    typedef struct packed {
        logic        req;
        logic [31:0] addr;
        logic [31:0] inst;
        logic [31:0] adder1;
        logic        flush;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        jump;
    logic [31:0] jump_target;
    logic [31:0] inst;
    logic [31:0] adder1;
    logic        flush;

    int unsigned errors;
    int unsigned checks;
    int          lat;
    int          cnt;
    exp_t        sb_q[$];

    fetch_unit_if bus ();

    fetch_unit #(
        .RESET_PC (32'h0000_0000)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .stall         (stall),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .jump          (jump),
        .jump_target   (jump_target),
        .imem          (bus),
        .inst          (inst),
        .adder1        (adder1),
        .flush         (flush)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Instruction memory: acks after `lat` waiting cycles, reset by the same rst.
    always_ff @(posedge clk) begin
        if (rst || !bus.imem_req || bus.imem_ack) cnt <= 0;
        else                                      cnt <= cnt + 1;
    end

    always_comb begin
        bus.imem_ack   = bus.imem_req && !rst && (cnt >= lat);
        bus.imem_rdata = bus.imem_addr ^ 32'hA5A5_0000;
    end

    function automatic logic [31:0] w(input logic [31:0] a);
        return a ^ 32'hA5A5_0000;
    endfunction

    function automatic exp_t ex(input logic rq, input logic [31:0] a, input logic [31:0] i,
                                input logic [31:0] ad, input logic f);
        exp_t e;
        e.req    = rq;
        e.addr   = a;
        e.inst   = i;
        e.adder1 = ad;
        e.flush  = f;
        return e;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // Queue the expectation for the current cycle, compare mid-cycle, then advance one clock.
    task automatic step(input string tag, input exp_t e);
        exp_t got;
        sb_q.push_back(e);
        @(negedge clk);
        got = sb_q.pop_front();
        chk({tag, ".req"},    {31'd0, bus.imem_req}, {31'd0, got.req});
        if (got.req) chk({tag, ".addr"}, bus.imem_addr, got.addr);
        chk({tag, ".inst"},   inst,   got.inst);
        chk({tag, ".adder1"}, adder1, got.adder1);
        chk({tag, ".flush"},  {31'd0, flush}, {31'd0, got.flush});
        @(posedge clk);
        #1;
    endtask

    initial begin
        errors = 0;
        checks = 0;
        lat = 0;
        rst = 1'b1;
        stall = 1'b0;
        branch_taken = 1'b0;
        branch_target = 32'd0;
        jump = 1'b0;
        jump_target = 32'd0;

        step("reset0", ex(1'b0, 32'd0, 32'd0, 32'd0, 1'b0));
        branch_taken = 1'b1; branch_target = 32'h40;
        step("reset_br", ex(1'b0, 32'd0, 32'd0, 32'd0, 1'b0));
        branch_taken = 1'b0;
        rst = 1'b0;

        // Zero-wait streaming.
        step("zw0", ex(1'b1, 32'h0, w(32'h0), 32'h4, 1'b0));
        step("zw4", ex(1'b1, 32'h4, w(32'h4), 32'h8, 1'b0));

        // Stall at pc=8 for two cycles.
        stall = 1'b1;
        step("st_a", ex(1'b1, 32'h8, w(32'h8), 32'hC, 1'b0));
        step("st_h", ex(1'b0, 32'h0, w(32'h8), 32'hC, 1'b0));
        stall = 1'b0;
        step("st_r", ex(1'b0, 32'h0, w(32'h8), 32'hC, 1'b0));
        step("st_n", ex(1'b1, 32'hC, w(32'hC), 32'h10, 1'b0));

        // Three-cycle ack latency.
        lat = 3;
        step("lat_b1", ex(1'b1, 32'h10, 32'd0, 32'd0, 1'b0));
        step("lat_b2", ex(1'b1, 32'h10, 32'd0, 32'd0, 1'b0));
        step("lat_b3", ex(1'b1, 32'h10, 32'd0, 32'd0, 1'b0));
        step("lat_ack", ex(1'b1, 32'h10, w(32'h10), 32'h14, 1'b0));
        lat = 0;
        step("zw14", ex(1'b1, 32'h14, w(32'h14), 32'h18, 1'b0));

        // Jump with zero-wait ack, then branch while a fetch of 0x10 is outstanding.
        jump = 1'b1; jump_target = 32'h10;
        step("jmp10", ex(1'b1, 32'h18, 32'd0, 32'd0, 1'b1));
        jump = 1'b0;
        lat = 2;
        branch_taken = 1'b1; branch_target = 32'h40;
        step("br40", ex(1'b1, 32'h10, 32'd0, 32'd0, 1'b1));
        branch_taken = 1'b0;
        step("drop_w", ex(1'b1, 32'h10, 32'd0, 32'd0, 1'b0));
        step("drop_ack", ex(1'b1, 32'h10, 32'd0, 32'd0, 1'b0));
        lat = 0;
        step("tgt40", ex(1'b1, 32'h40, w(32'h40), 32'h44, 1'b0));

        // Second redirect while still draining overwrites the target.
        lat = 2;
        jump = 1'b1; jump_target = 32'h80;
        step("jmp80", ex(1'b1, 32'h44, 32'd0, 32'd0, 1'b1));
        jump = 1'b0;
        branch_taken = 1'b1; branch_target = 32'h90;
        step("drop_br", ex(1'b1, 32'h44, 32'd0, 32'd0, 1'b1));
        branch_taken = 1'b0;
        step("drop_ack2", ex(1'b1, 32'h44, 32'd0, 32'd0, 1'b0));
        lat = 0;
        step("tgt90", ex(1'b1, 32'h90, w(32'h90), 32'h94, 1'b0));

        // Branch and jump together under stall; misaligned branch target is word aligned.
        stall = 1'b1;
        branch_taken = 1'b1; branch_target = 32'h103;
        jump = 1'b1; jump_target = 32'h200;
        step("both", ex(1'b1, 32'h94, 32'd0, 32'd0, 1'b1));
        branch_taken = 1'b0; jump = 1'b0; stall = 1'b0;
        step("tgt100", ex(1'b1, 32'h100, w(32'h100), 32'h104, 1'b0));

        // Redirect while holding.
        stall = 1'b1;
        step("h_cap", ex(1'b1, 32'h104, w(32'h104), 32'h108, 1'b0));
        jump = 1'b1; jump_target = 32'h20;
        step("h_jmp", ex(1'b0, 32'h0, 32'd0, 32'd0, 1'b1));
        jump = 1'b0; stall = 1'b0;
        step("tgt20", ex(1'b1, 32'h20, w(32'h20), 32'h24, 1'b0));

        // PC wrap.
        jump = 1'b1; jump_target = 32'hFFFF_FFFC;
        step("jmp_top", ex(1'b1, 32'h24, 32'd0, 32'd0, 1'b1));
        jump = 1'b0;
        step("top", ex(1'b1, 32'hFFFF_FFFC, w(32'hFFFF_FFFC), 32'h0, 1'b0));
        step("wrap0", ex(1'b1, 32'h0, w(32'h0), 32'h4, 1'b0));

        // Reset mid-wait abandons the request.
        lat = 3;
        step("mw", ex(1'b1, 32'h4, 32'd0, 32'd0, 1'b0));
        rst = 1'b1;
        step("mw_rst", ex(1'b0, 32'h0, 32'd0, 32'd0, 1'b0));
        rst = 1'b0; lat = 0;
        step("restart", ex(1'b1, 32'h0, w(32'h0), 32'h4, 1'b0));
        step("restart4", ex(1'b1, 32'h4, w(32'h4), 32'h8, 1'b0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: bench did not complete");
        $fatal(1);
    end

endmodule
